otp_ctrl_otp_arb: RTL and testbench

Arbitrates the single OTP macro command interface between NumReq requesters (DAI, LCI, partition readers, scrambling/KDI) inside otp_ctrl. Round-robin with request locking until grant. Tracks outstanding transactions in an ID FIFO so each macro response (rvalid/rdata/err) returns to the requester that issued it. Flags protocol violations for the otp_ctrl error/alert logic.

---
 rtl/otp_ctrl_otp_arb.sv | 157 +++++++++++++++
 tb/tb_otp_ctrl_otp_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_ctrl_otp_arb.sv
// OTP macro command arbiter: round-robin with lock-until-grant,
// ID FIFO routing of macro responses and sticky protocol error flag.
module otp_ctrl_otp_arb #(
   parameter  int NumReq         = 4,
   parameter  int MaxOutstanding = 2,
   parameter  int SizeW          = 2,
   parameter  int WdataW         = 16,
   parameter  int AddrW          = 10,
   parameter  int RdataW         = 64,
   localparam int IdW            = $clog2(NumReq)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0][2:0]        cmd_i,
   input  logic [NumReq-1:0][SizeW-1:0]  size_i,
   input  logic [NumReq-1:0][WdataW-1:0] wdata_i,
   input  logic [NumReq-1:0][AddrW-1:0]  addr_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rvalid_o,
   output logic [RdataW-1:0]             rdata_o,
   output logic [2:0]                    err_o,
   output logic                          otp_req_o,
   output logic [2:0]                    otp_cmd_o,
   output logic [SizeW-1:0]              otp_size_o,
   output logic [WdataW-1:0]             otp_wdata_o,
   output logic [AddrW-1:0]              otp_addr_o,
   input  logic                          otp_gnt_i,
   input  logic                          otp_rvalid_i,
   input  logic [RdataW-1:0]             otp_rdata_i,
   input  logic [2:0]                    otp_err_i,
   output logic                          proto_err_o,
   output logic                          idle_o
);

   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);

   function automatic logic [IdW-1:0] add_mod(input logic [IdW-1:0] a,
                                              input logic [IdW-1:0] b);
      logic [IdW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IdW+1)'(NumReq)) s = s - (IdW+1)'(NumReq);
      return s[IdW-1:0];
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   logic                               lock_q;
   logic [IdW-1:0]                     lock_idx_q;
   logic [IdW-1:0]                     rr_q;
   logic [MaxOutstanding-1:0][IdW-1:0] fifo_q;
   logic [PtrW-1:0]                    wr_q;
   logic [PtrW-1:0]                    rd_q;
   logic [CntW-1:0]                    cnt_q;
   logic                               perr_q;

   logic                  full;
   logic                  empty;
   logic [2*NumReq-1:0]   req_dbl;
   logic [2*NumReq-1:0]   req_shift;
   logic [NumReq-1:0]     rot;
   logic [IdW-1:0]        off;
   logic [IdW-1:0]        win;
   logic [IdW-1:0]        sel;
   logic [IdW-1:0]        head;
   logic                  otp_req;
   logic                  drop;
   logic                  hs;
   logic                  pop;
   logic                  rsp_on;
   logic                  perr_set;

   assign full  = (cnt_q == CntW'(MaxOutstanding));
   assign empty = (cnt_q == '0);

   // Rotate requests so bit 0 is the round-robin pointer position.
   assign req_dbl   = {req_i, req_i};
   assign req_shift = req_dbl >> rr_q;
   assign rot       = req_shift[NumReq-1:0];

   always_comb begin
      off = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (rot[i]) off = IdW'(i);
      end
   end

   assign win = add_mod(rr_q, off);

   always_comb begin
      sel     = '0;
      otp_req = 1'b0;
      drop    = 1'b0;
      if (!rst_i) begin
         if (lock_q) begin
            if (req_i[lock_idx_q]) begin
               otp_req = 1'b1;
               sel     = lock_idx_q;
            end else begin
               drop = 1'b1;
            end
         end else if (!full && (|req_i)) begin
            otp_req = 1'b1;
            sel     = win;
         end
      end
   end

   assign hs     = otp_req & otp_gnt_i;
   assign head   = fifo_q[rd_q];
   assign pop    = ~rst_i & otp_rvalid_i & ~empty;
   assign rsp_on = ~rst_i & otp_rvalid_i;

   assign perr_set = (otp_rvalid_i & empty) | drop | (otp_gnt_i & ~otp_req);

   assign gnt_o       = hs  ? (NumReq'(1) << sel)  : '0;
   assign rvalid_o    = pop ? (NumReq'(1) << head) : '0;
   assign rdata_o     = rsp_on ? otp_rdata_i : '0;
   assign err_o       = rsp_on ? otp_err_i   : '0;
   assign otp_req_o   = otp_req;
   assign otp_cmd_o   = otp_req ? cmd_i[sel]   : '0;
   assign otp_size_o  = otp_req ? size_i[sel]  : '0;
   assign otp_wdata_o = otp_req ? wdata_i[sel] : '0;
   assign otp_addr_o  = otp_req ? addr_i[sel]  : '0;
   assign proto_err_o = perr_q;
   assign idle_o      = rst_i | (~lock_q & empty);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q <= 1'b0;
         rr_q   <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         perr_q <= 1'b0;
      end else begin
         if (hs) begin
            lock_q       <= 1'b0;
            rr_q         <= add_mod(sel, IdW'(1));
            fifo_q[wr_q] <= sel;
            wr_q         <= ptr_inc(wr_q);
         end else if (otp_req) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
         end else if (drop) begin
            lock_q <= 1'b0;
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CntW'(hs) - CntW'(pop);
         if (perr_set) perr_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_otp_ctrl_otp_arb.sv
// Bench for otp_ctrl_otp_arb: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_otp_ctrl_otp_arb;
   localparam int N  = 4;
   localparam int M  = 2;
   localparam int SW = 2;
   localparam int WW = 16;
   localparam int AW = 10;
   localparam int RW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]         req;
   logic [N-1:0][2:0]    cmd;
   logic [N-1:0][SW-1:0] size;
   logic [N-1:0][WW-1:0] wdata;
   logic [N-1:0][AW-1:0] addr;
   logic                 gnt_in;
   logic                 rv_in;
   logic [RW-1:0]        rd_in;
   logic [2:0]           err_in;

   logic [N-1:0]  gnt_o;
   logic [N-1:0]  rvalid_o;
   logic [RW-1:0] rdata_o;
   logic [2:0]    err_o;
   logic          otp_req_o;
   logic [2:0]    otp_cmd_o;
   logic [SW-1:0] otp_size_o;
   logic [WW-1:0] otp_wdata_o;
   logic [AW-1:0] otp_addr_o;
   logic          proto_err_o;
   logic          idle_o;

   otp_ctrl_otp_arb #(
      .NumReq(N), .MaxOutstanding(M), .SizeW(SW),
      .WdataW(WW), .AddrW(AW), .RdataW(RW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_i(req), .cmd_i(cmd), .size_i(size),
      .wdata_i(wdata), .addr_i(addr),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o),
      .otp_req_o(otp_req_o), .otp_cmd_o(otp_cmd_o),
      .otp_size_o(otp_size_o), .otp_wdata_o(otp_wdata_o),
      .otp_addr_o(otp_addr_o), .otp_gnt_i(gnt_in),
      .otp_rvalid_i(rv_in), .otp_rdata_i(rd_in),
      .otp_err_i(err_in), .proto_err_o(proto_err_o),
      .idle_o(idle_o)
   );

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // Model state
   int mq[$];
   bit mlock;
   int mlidx;
   int mrr;
   bit mperr;
   bit e_oreq, e_hs, e_pop, e_drop;
   int e_sel;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Mid-cycle: derive expected outputs and compare.
   task automatic settle();
      logic [63:0] eg, er;
      #3;
      e_oreq = 0; e_sel = 0; e_drop = 0;
      if (!rst) begin
         if (mlock) begin
            if (req[mlidx]) begin e_oreq = 1; e_sel = mlidx; end
            else e_drop = 1;
         end else if (mq.size() < M && req != 0) begin
            for (int k = 0; k < N; k++) begin
               if (!e_oreq && req[(mrr + k) % N]) begin
                  e_oreq = 1; e_sel = (mrr + k) % N;
               end
            end
         end
      end
      e_hs  = e_oreq & gnt_in;
      e_pop = !rst && rv_in && mq.size() > 0;
      eg = 0; er = 0;
      if (e_hs) eg = 64'd1 << e_sel;
      if (e_pop) er = 64'd1 << mq[0];
      chk("otp_req", otp_req_o, e_oreq);
      chk("gnt", gnt_o, eg);
      chk("otp_cmd", otp_cmd_o, e_oreq ? cmd[e_sel] : 3'd0);
      chk("otp_size", otp_size_o, e_oreq ? size[e_sel] : '0);
      chk("otp_wdata", otp_wdata_o, e_oreq ? wdata[e_sel] : '0);
      chk("otp_addr", otp_addr_o, e_oreq ? addr[e_sel] : '0);
      chk("rvalid", rvalid_o, er);
      if (e_pop || !rv_in || rst) begin
         chk("rdata", rdata_o, e_pop ? rd_in : '0);
         chk("err", err_o, e_pop ? err_in : 3'd0);
      end
      chk("proto_err", proto_err_o, mperr);
      chk("idle", idle_o, rst ? 1'b1 : (!mlock && mq.size() == 0));
   endtask

   task automatic advance();
      if (rst) begin
         mq.delete(); mlock = 0; mrr = 0; mperr = 0;
      end else begin
         if (rv_in && mq.size() == 0) mperr = 1;
         if (gnt_in && !e_oreq) mperr = 1;
         if (e_drop) begin mperr = 1; mlock = 0; end
         if (e_pop) void'(mq.pop_front());
         if (e_hs) begin
            mq.push_back(e_sel);
            mrr = (e_sel + 1) % N;
            mlock = 0;
         end else if (e_oreq) begin
            mlock = 1; mlidx = e_sel;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic idle_inputs();
      req = '0; gnt_in = 0; rv_in = 0; rd_in = '0; err_in = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   int exp_g[6] = '{1, 2, 4, 8, 1, 2};
   int exp_r[6] = '{0, 1, 2, 4, 8, 1};

   initial begin
      idle_inputs();
      cmd = '0; size = '0; wdata = '0; addr = '0;
      mlock = 0; mrr = 0; mperr = 0; mlidx = 0;
      @(posedge clk);
      #1;
      step();
      settle();
      chk("reset idle", idle_o, 1'b1);
      chk("reset otp_req", otp_req_o, 1'b0);
      advance();
      rst = 0;

      // Single transaction
      addr[0] = 10'h155; req = 4'b0001; gnt_in = 1;
      settle();
      chk("single gnt", gnt_o, 4'b0001);
      chk("single addr", otp_addr_o, 10'h155);
      advance();
      idle_inputs();
      step();
      step();
      rv_in = 1; rd_in = 64'hA5A5;
      settle();
      chk("single rvalid", rvalid_o, 4'b0001);
      chk("single rdata", rdata_o, 64'hA5A5);
      advance();
      idle_inputs();
      settle();
      chk("single idle", idle_o, 1'b1);
      advance();

      // Round robin
      do_reset();
      req = 4'b1111; gnt_in = 1;
      for (int k = 0; k < 6; k++) begin
         rv_in = (k > 0);
         settle();
         chk("rr gnt", gnt_o, exp_g[k]);
         chk("rr rvalid", rvalid_o, exp_r[k]);
         advance();
      end
      idle_inputs(); rv_in = 1;
      step();
      idle_inputs();

      // Lock
      do_reset();
      addr[1] = 10'h1AA; addr[0] = 10'h033; req = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         if (k == 2) req = 4'b0011;
         settle();
         chk("lock addr", otp_addr_o, 10'h1AA);
         advance();
      end
      gnt_in = 1;
      settle();
      chk("lock gnt1", gnt_o, 4'b0010);
      advance();
      req = 4'b0001;
      settle();
      chk("lock gnt0", gnt_o, 4'b0001);
      advance();
      idle_inputs(); rv_in = 1;
      step();
      step();
      idle_inputs();

      // FIFO full
      do_reset();
      req = 4'b0001; gnt_in = 1;
      step();
      req = 4'b0010;
      step();
      req = 4'b0100; gnt_in = 0;
      settle();
      chk("full block", otp_req_o, 1'b0);
      advance();
      rv_in = 1;
      settle();
      chk("full pop no unblock", otp_req_o, 1'b0);
      chk("full rvalid", rvalid_o, 4'b0001);
      advance();
      rv_in = 0; gnt_in = 1;
      settle();
      chk("full reissue", otp_req_o, 1'b1);
      advance();
      idle_inputs(); rv_in = 1;
      step();
      step();
      idle_inputs();

      // Error routing
      do_reset();
      cmd[3] = 3'd0; req = 4'b1000; gnt_in = 1;
      step();
      idle_inputs(); rv_in = 1; err_in = 3'd2; rd_in = 64'h1234;
      settle();
      chk("err rvalid", rvalid_o, 4'b1000);
      chk("err code", err_o, 3'd2);
      chk("err no proto", proto_err_o, 1'b0);
      advance();
      idle_inputs();

      // Response with empty FIFO
      do_reset();
      rv_in = 1;
      settle();
      chk("viol no rvalid", rvalid_o, 4'b0000);
      advance();
      rv_in = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("viol sticky", proto_err_o, 1'b1);
         advance();
      end
      rst = 1;
      step();
      rst = 0;
      settle();
      chk("viol cleared", proto_err_o, 1'b0);
      advance();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         for (int i = 0; i < N; i++) begin
            cmd[i]   = 3'($urandom);
            size[i]  = SW'($urandom);
            wdata[i] = WW'($urandom);
            addr[i]  = AW'($urandom);
         end
         gnt_in = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0) rv_in = 1'($urandom);
         else rv_in = ($urandom_range(0, 49) == 0);
         rd_in  = {$urandom, $urandom};
         err_in = 3'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
